// File: rtl/regfile_pkg.sv
// Shared constants for the register file: register count, address/data widths
// and the address of the hardwired-zero register.
package regfile_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a word from the flattened register
// bus by address and forces the zero register to read as 0.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [(2**ADDR_W)*DATA_W-1:0] words,
   input  logic [ADDR_W-1:0]             addr,
   output logic [DATA_W-1:0]             data
);

   localparam int N = 2**ADDR_W;

   logic [DATA_W-1:0] word_array [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign word_array[gi] = words[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // The zero rule is applied here too, so r0 reads 0 whatever its slot carries.
   always_comb begin
      data = word_array[addr];
      if (addr == ADDR_W'(REG_ZERO)) begin
         data = '0;
      end
   end

endmodule

// File: rtl/regfile.sv
// 2-read/1-write register file: r0 hardwired to zero, asynchronous clear,
// combinational reads without write-to-read bypass.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] readReg1_in,
   input  logic [ADDR_W-1:0] readReg2_in,
   input  logic [ADDR_W-1:0] writeReg_in,
   input  logic [DATA_W-1:0] writeData_in,
   output logic [DATA_W-1:0] data1_out,
   output logic [DATA_W-1:0] data2_out
);

   localparam int N = 2**ADDR_W;

   logic [N*DATA_W-1:0] words;
   logic [N-1:1]        write_sel;

   // r0 owns no storage; its slot on the read bus is a constant zero.
   assign words[DATA_W-1:0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < N; gi++) begin : g_reg
         logic [DATA_W-1:0] value;

         assign write_sel[gi] = enable && (writeReg_in == ADDR_W'(gi));

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               value <= '0;
            end else if (write_sel[gi]) begin
               value <= writeData_in;
            end
         end

         assign words[gi*DATA_W +: DATA_W] = value;
      end
   endgenerate

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read1 (
      .words (words),
      .addr  (readReg1_in),
      .data  (data1_out)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_read2 (
      .words (words),
      .addr  (readReg2_in),
      .data  (data2_out)
   );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed table, hand-written edge/reset sequences and
// randomized traffic against an array model of the 32 registers.
module tb_regfile;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [31:0] d1;
   logic [31:0] d2;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model [32];

   typedef struct {
      logic        en;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t table_v [18];

   always #5 clk = ~clk;

   regfile #(
      .DATA_W (32),
      .ADDR_W (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .readReg1_in  (ra1),
      .readReg2_in  (ra2),
      .writeReg_in  (wa),
      .writeData_in (wd),
      .data1_out    (d1),
      .data2_out    (d2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   initial begin
      model_clear();

      // Reset pulse with a write held during it; every address reads 0.
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      enable = 1'b1;
      wa     = 5'd9;
      wd     = 32'h99;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         #1;
         check($sformatf("reset sweep d1 a=%0d", a), d1, 32'h0);
         check($sformatf("reset sweep d2 a=%0d", a), d2, 32'h0);
      end
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      ra1    = 5'd9;
      #1 check("write during reset not stored", d1, 32'h0);

      // Fill register k with k.
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         enable = 1'b1;
         wa     = 5'(k);
         wd     = 32'(k);
         @(posedge clk);
         if (k != 0) model[k] = 32'(k);
      end
      @(negedge clk);
      enable = 1'b0;

      for (int i = 0; i < 16; i++) begin
         table_v[i] = '{1'b0, 5'd5, 32'hDEADBEEF, 5'(2*i), 5'(2*i+1),
                        (i == 0) ? 32'h0 : 32'(2*i), 32'(2*i+1)};
      end
      table_v[16] = '{1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'd5, 32'd5};
      table_v[17] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         enable = table_v[i].en;
         wa     = table_v[i].waddr;
         wd     = table_v[i].wdata;
         ra1    = table_v[i].a1;
         ra2    = table_v[i].a2;
         @(posedge clk);
         #1;
         check($sformatf("table[%0d] d1", i), d1, table_v[i].e1);
         check($sformatf("table[%0d] d2", i), d2, table_v[i].e2);
      end

      // Same-register read and write: old value before the edge, new after.
      @(negedge clk);
      enable = 1'b1;
      wa     = 5'd7;
      wd     = 32'h77;
      ra1    = 5'd7;
      ra2    = 5'd7;
      #1;
      check("r7 pre-edge d1", d1, 32'd7);
      check("r7 pre-edge d2", d2, 32'd7);
      @(posedge clk);
      model[7] = 32'h77;
      #1;
      check("r7 post-edge d1", d1, 32'h77);
      check("r7 post-edge d2", d2, 32'h77);

      // Reset asserted between edges while a write to r3 is held.
      @(negedge clk);
      wa  = 5'd3;
      wd  = 32'h333;
      ra1 = 5'd3;
      ra2 = 5'd31;
      #1;
      check("pre mid-reset d1", d1, 32'd3);
      check("pre mid-reset d2", d2, 32'd31);
      #1 reset = 1'b1;
      model_clear();
      #1;
      check("mid-reset immediate d1", d1, 32'h0);
      check("mid-reset immediate d2", d2, 32'h0);
      @(posedge clk);
      #1;
      check("mid-reset edge d1", d1, 32'h0);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      #1;
      check("after mid-reset r3", d1, 32'h0);
      check("after mid-reset r31", d2, 32'h0);

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         reset  = ($urandom_range(0, 24) == 0);
         enable = 1'($urandom_range(0, 1));
         wa     = 5'($urandom);
         wd     = $urandom;
         ra1    = 5'($urandom);
         ra2    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
         if (reset) model_clear();
         #1;
         check($sformatf("rand[%0d] pre d1 a=%0d", n, ra1), d1, model_read(ra1));
         check($sformatf("rand[%0d] pre d2 a=%0d", n, ra2), d2, model_read(ra2));
         @(posedge clk);
         if (!reset && enable && wa != 5'd0) model[wa] = wd;
         #1;
         check($sformatf("rand[%0d] post d1 a=%0d", n, ra1), d1, model_read(ra1));
         check($sformatf("rand[%0d] post d2 a=%0d", n, ra2), d2, model_read(ra2));
      end
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL declare DATA_W, default 32, as the register and data-port width.
REQ-002 The block SHALL declare ADDR_W, default 5, as the register-address width, giving 2**ADDR_W = 32 registers.
Ports (name  direction  width  meaning):
REQ-003 The block SHALL have port clk  input  1  single clock; all writes occur on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  write enable.
REQ-006 The block SHALL have port readReg1_in  input  ADDR_W  read port 1 address.
REQ-007 The block SHALL have port readReg2_in  input  ADDR_W  read port 2 address.
REQ-008 The block SHALL have port writeReg_in  input  ADDR_W  write address.
REQ-009 The block SHALL have port writeData_in  input  DATA_W  write data.
REQ-010 The block SHALL have port data1_out  output  DATA_W  contents of register readReg1_in.
REQ-011 The block SHALL have port data2_out  output  DATA_W  contents of register readReg2_in.

Function
REQ-012 The block SHALL hold 32 general registers of DATA_W bits, r0..r31.
REQ-013 On each rising clk edge with enable=1 and reset=0, the block SHALL load writeData_in into the register addressed by writeReg_in.
REQ-014 With enable=0, the block SHALL leave all registers unchanged.
REQ-015 Register r0 SHALL be hardwired to zero: writes to address 0 are discarded and reads of address 0 always return 0.
REQ-016 Both read ports SHALL be combinational, independent and asynchronous to clk, with zero-cycle latency from an address change to the output.
REQ-017 Both read ports SHALL be able to address the same register at once, and both SHALL return identical data.
REQ-018 When a read and a write target the same register in the same cycle, the read SHALL return the old value before the edge and the new value immediately after it, with no internal write-to-read bypass.
REQ-019 An X or undriven read address SHALL NOT affect stored state.
REQ-020 Writes SHALL take effect one edge after presentation, and reads of the written register SHALL reflect the new value in the same cycle after that edge.

Reset
REQ-021 While reset=1, the block SHALL asynchronously clear all registers to 0, regardless of clk or enable.
REQ-022 While reset=1, data1_out and data2_out SHALL read 0 for every address.
REQ-023 While reset=1, the block SHALL ignore writes presented during reset.
REQ-024 The first write after reset deassertion SHALL occur on the first rising edge at which reset=0 and enable=1.
REQ-025 A reset asserted mid-sequence SHALL discard all prior writes.

Structure
REQ-026 A shared package SHALL define REG_COUNT=32, REG_ADDR_W=5, REG_DATA_W=32, and REG_ZERO=5'd0.
REQ-027 The block SHALL be a single module containing the storage array, the write-decode logic and two read multiplexers.
REQ-028 One sub-module, regfile_read_port (an address-to-data mux with the r0=0 rule), SHALL be instantiated twice.
REQ-029 The block SHALL contain no other hierarchy.

Verification
REQ-030 Bench SHALL cover: reset=1 pulse, then read addresses 0..31 -> all outputs 0.
REQ-031 Bench SHALL cover: enable=1, write value k to register k for k=0..31, one per cycle; then read pairs (0,1),(2,3)..(30,31) -> data1=0 for r0, otherwise data1=even k, data2=odd k.
REQ-032 Bench SHALL cover: enable=0, write 32'hDEADBEEF to r5 -> r5 still reads 5.
REQ-033 Bench SHALL cover: write 32'hFFFFFFFF to r0 with enable=1 -> r0 reads 0 on both ports.
REQ-034 Bench SHALL cover: read r7 on port 1 while writing 32'h77 to r7 -> old value 7 before the edge, 32'h77 right after it; port 2 at r7 matches port 1.
REQ-035 Bench SHALL cover: assert reset mid-cycle, between edges, after the fill -> all reads drop to 0 immediately, and a write held during reset is not stored.
